// File: rtl/bakraid_gfx_pkg.sv
// Shared sizing, channel numbering and FSM encoding for the GFX ROM fetch arbiter.
// Channel c serves layer c>>1 (OBJ, SCR0, SCR1, SCR2) on chip c[0] (GFX0/GFX1).
package bakraid_gfx_pkg;

    localparam int GFX_NCH = 8;
    localparam int GFX_AW  = 22;
    localparam int GFX_DW  = 32;

    localparam int CH_OBJ0   = 0;
    localparam int CH_OBJ1   = 1;
    localparam int CH_SCR0_0 = 2;
    localparam int CH_SCR0_1 = 3;
    localparam int CH_SCR1_0 = 4;
    localparam int CH_SCR1_1 = 5;
    localparam int CH_SCR2_0 = 6;
    localparam int CH_SCR2_1 = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bakraid_rr_pick.sv
// Round-robin picker: first set request strictly after i_ptr, wrapping modulo NCH.
// Purely combinational; no state.
module bakraid_rr_pick #(
    parameter int NCH = 8,
    parameter int PW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [PW-1:0]  i_ptr,
    output logic [PW-1:0]  o_gnt,
    output logic           o_any
);

    logic [PW-1:0] w_idx;

    // Walk from the farthest candidate back to ptr+1 so the nearest request wins last.
    always_comb begin
        o_gnt = '0;
        w_idx = '0;
        for (int i = NCH; i >= 1; i--) begin
            w_idx = PW'((int'(i_ptr) + i) % NCH);
            if (i_req[w_idx]) begin
                o_gnt = w_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/bakraid_gfx_arb.sv
// GFX ROM fetch arbiter: per-channel 1-entry cache, hits answered in 0 cycles,
// misses granted round-robin to a single shared SDRAM read port, one read in flight.
module bakraid_gfx_arb
    import bakraid_gfx_pkg::*;
#(
    parameter int NCH = GFX_NCH,
    parameter int AW  = GFX_AW,
    parameter int DW  = GFX_DW
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              FLUSH,
    input  logic [NCH-1:0]    CH_CS,
    input  logic [NCH*AW-1:0] CH_ADDR,
    output logic [NCH-1:0]    CH_OK,
    output logic [NCH*DW-1:0] CH_DOUT,
    output logic              SD_REQ,
    output logic [AW:0]       SD_ADDR,
    input  logic              SD_OK,
    input  logic [DW-1:0]     SD_DATA
);

    localparam int PW = $clog2(NCH);

    arb_state_e     r_state;
    logic [PW-1:0]  r_gnt;
    logic [PW-1:0]  r_ptr;
    logic           r_sd_req;
    logic [AW:0]    r_sd_addr;
    logic [NCH-1:0] r_valid;
    logic [AW-1:0]  r_tag  [NCH];
    logic [DW-1:0]  r_data [NCH];

    logic [AW-1:0]  w_addr [NCH];
    logic [NCH-1:0] w_hit;
    logic [NCH-1:0] w_miss;
    logic [PW-1:0]  w_pick;
    logic           w_any;
    logic           w_busy;
    logic           w_fill;

    assign w_busy = (r_state == ST_BUSY);
    assign w_fill = w_busy & SD_OK;

    // The channel being served is not a miss; otherwise it would be re-queued behind itself.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign w_addr[c]           = CH_ADDR[c*AW +: AW];
        assign w_hit[c]            = CH_CS[c] & r_valid[c] & (r_tag[c] == w_addr[c]);
        assign w_miss[c]           = CH_CS[c] & ~w_hit[c] & ~(w_busy & (r_gnt == PW'(c)));
        assign CH_DOUT[c*DW +: DW] = r_data[c];
    end

    assign CH_OK   = w_hit;
    assign SD_REQ  = r_sd_req;
    assign SD_ADDR = r_sd_addr;

    bakraid_rr_pick #(
        .NCH (NCH),
        .PW  (PW)
    ) u_pick (
        .i_req (w_miss),
        .i_ptr (r_ptr),
        .o_gnt (w_pick),
        .o_any (w_any)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_ptr     <= PW'(NCH - 1);
            r_sd_req  <= 1'b0;
            r_sd_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt     <= w_pick;
                        r_ptr     <= w_pick;
                        r_sd_addr <= {w_pick[0], w_addr[w_pick]};
                        r_sd_req  <= 1'b1;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (SD_OK) begin
                        r_sd_req <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A flush landing on the fill cycle wins: the returned word is dropped.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_valid <= '0;
        end else if (FLUSH) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[r_gnt] <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int c = 0; c < NCH; c++) begin
                r_tag[c]  <= '0;
                r_data[c] <= '0;
            end
        end else if (w_fill && !FLUSH) begin
            r_tag[r_gnt]  <= r_sd_addr[AW-1:0];
            r_data[r_gnt] <= SD_DATA;
        end
    end

endmodule

// File: tb/tb_bakraid_gfx_arb.sv
// Directed bench for bakraid_gfx_arb with hand-computed expectations.
module tb_bakraid_gfx_arb;

    localparam int NCH = 8;
    localparam int AW  = 22;
    localparam int DW  = 32;

    logic              CLK;
    logic              RESET_N;
    logic              FLUSH;
    logic [NCH-1:0]    CH_CS;
    logic [NCH*AW-1:0] CH_ADDR;
    logic [NCH-1:0]    CH_OK;
    logic [NCH*DW-1:0] CH_DOUT;
    logic              SD_REQ;
    logic [AW:0]       SD_ADDR;
    logic              SD_OK;
    logic [DW-1:0]     SD_DATA;

    logic [AW-1:0]     addr [NCH];

    int n_chk = 0;
    int n_err = 0;

    for (genvar c = 0; c < NCH; c++) begin : g_addr
        assign CH_ADDR[c*AW +: AW] = addr[c];
    end

    bakraid_gfx_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .FLUSH   (FLUSH),
        .CH_CS   (CH_CS),
        .CH_ADDR (CH_ADDR),
        .CH_OK   (CH_OK),
        .CH_DOUT (CH_DOUT),
        .SD_REQ  (SD_REQ),
        .SD_ADDR (SD_ADDR),
        .SD_OK   (SD_OK),
        .SD_DATA (SD_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] dout(input int c);
        return CH_DOUT[c*DW +: DW];
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 50 && SD_REQ !== 1'b1; i++) cyc();
        chk(tag, 64'(SD_REQ), 64'd1);
    endtask

    task automatic sd_reply(input int lat, input logic [DW-1:0] d);
        repeat (lat) cyc();
        SD_OK   = 1'b1;
        SD_DATA = d;
        cyc();
        SD_OK   = 1'b0;
        SD_DATA = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [AW:0] e;
        int          hits;

        RESET_N = 1'b0;
        FLUSH   = 1'b0;
        SD_OK   = 1'b0;
        SD_DATA = '0;
        CH_CS   = 8'hFF;
        for (int c = 0; c < NCH; c++) addr[c] = 22'(22'h000100 + c);

        // Reset state with every channel requesting
        repeat (3) cyc();
        chk("rst_sd_req", 64'(SD_REQ), 64'd0);
        chk("rst_sd_addr", 64'(SD_ADDR), 64'd0);
        chk("rst_ch_ok", 64'(CH_OK), 64'd0);
        chk("rst_ch_dout", 64'(|CH_DOUT), 64'd0);

        // Release: first grant is ch0, then 1..7, then ch0's new miss last
        RESET_N = 1'b1;
        cyc();
        chk("first_gnt_req", 64'(SD_REQ), 64'd1);
        chk("first_gnt_addr", 64'(SD_ADDR), 64'({1'b0, 22'h000100}));
        for (int k = 0; k < NCH; k++) begin
            wait_req("rr_req");
            e = {1'(k & 1), 22'(22'h000100 + k)};
            chk($sformatf("rr_addr_%0d", k), 64'(SD_ADDR), 64'(e));
            sd_reply(2, 32'hC0DE0000 | k);
            if (k == 0) addr[0] = 22'h000200;
        end
        wait_req("rr_again_req");
        chk("rr_ch0_last", 64'(SD_ADDR), 64'({1'b0, 22'h000200}));
        sd_reply(2, 32'hC0DE0100);
        chk("rr_all_ok", 64'(CH_OK), 64'hFF);
        chk("rr_dout_0", 64'(dout(0)), 64'hC0DE0100);
        for (int c = 1; c < NCH; c++) chk($sformatf("rr_dout_%0d", c), 64'(dout(c)), 64'(32'hC0DE0000 | c));

        // Single miss on ch3 with 4-cycle SDRAM latency
        CH_CS   = 8'h08;
        addr[3] = 22'h012345;
        #1;
        chk("sm_miss_ok", 64'(CH_OK[3]), 64'd0);
        wait_req("sm_req");
        chk("sm_addr", 64'(SD_ADDR), 64'h412345);
        repeat (4) cyc();
        chk("sm_req_held", 64'(SD_REQ), 64'd1);
        SD_OK   = 1'b1;
        SD_DATA = 32'hDEADBEEF;
        #1;
        chk("sm_ok_not_yet", 64'(CH_OK[3]), 64'd0);
        cyc();
        SD_OK   = 1'b0;
        SD_DATA = '0;
        chk("sm_ok", 64'(CH_OK[3]), 64'd1);
        chk("sm_dout", 64'(dout(3)), 64'hDEADBEEF);
        chk("sm_req_drop", 64'(SD_REQ), 64'd0);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (SD_REQ === 1'b1) hits++;
        end
        chk("sm_no_new_req", 64'(hits), 64'd0);
        CH_CS = 8'h00;
        cyc();
        chk("sm_cs_off_ok", 64'(CH_OK[3]), 64'd0);
        CH_CS = 8'h08;
        #1;
        chk("sm_rehit_same_cycle", 64'(CH_OK[3]), 64'd1);

        // Address change on ch5 while its read is in flight
        CH_CS   = 8'h20;
        addr[5] = 22'h0AAAAA;
        wait_req("ac_req_a");
        chk("ac_addr_a", 64'(SD_ADDR), 64'({1'b1, 22'h0AAAAA}));
        cyc();
        addr[5] = 22'h0BBBBB;
        sd_reply(2, 32'hAAAA0005);
        chk("ac_stale_not_ok", 64'(CH_OK[5]), 64'd0);
        wait_req("ac_req_b");
        chk("ac_addr_b", 64'(SD_ADDR), 64'({1'b1, 22'h0BBBBB}));
        chk("ac_busy_not_ok", 64'(CH_OK[5]), 64'd0);
        sd_reply(1, 32'hBBBB0005);
        chk("ac_ok_b", 64'(CH_OK[5]), 64'd1);
        chk("ac_dout_b", 64'(dout(5)), 64'hBBBB0005);

        // FLUSH coincident with SD_OK for ch1; ch2 was a hit before
        addr[1] = 22'h0011AA;
        CH_CS   = 8'h06;
        #1;
        chk("fl_ch2_hit_before", 64'(CH_OK[2]), 64'd1);
        wait_req("fl_req");
        chk("fl_addr", 64'(SD_ADDR), 64'({1'b1, 22'h0011AA}));
        cyc();
        SD_OK   = 1'b1;
        SD_DATA = 32'h11111111;
        FLUSH   = 1'b1;
        cyc();
        SD_OK   = 1'b0;
        FLUSH   = 1'b0;
        chk("fl_ch1_not_ok", 64'(CH_OK[1]), 64'd0);
        chk("fl_ch2_dropped", 64'(CH_OK[2]), 64'd0);
        chk("fl_req_drop", 64'(SD_REQ), 64'd0);
        wait_req("fl_req_ch2");
        chk("fl_addr_ch2", 64'(SD_ADDR), 64'({1'b0, 22'h000102}));
        sd_reply(1, 32'h22222222);
        wait_req("fl_req_ch1");
        chk("fl_addr_ch1", 64'(SD_ADDR), 64'({1'b1, 22'h0011AA}));
        sd_reply(1, 32'h11112222);
        chk("fl_both_ok", 64'(CH_OK[2:1]), 64'd3);
        chk("fl_dout_ch1", 64'(dout(1)), 64'h11112222);

        // Reset while a read is in flight, then a late SD_OK
        CH_CS   = 8'h10;
        addr[4] = 22'h044444;
        wait_req("rb_req");
        RESET_N = 1'b0;
        #1;
        chk("rb_req_async", 64'(SD_REQ), 64'd0);
        chk("rb_ok_clear", 64'(CH_OK), 64'd0);
        CH_CS = 8'h00;
        cyc();
        RESET_N = 1'b1;
        cyc();
        chk("rb_idle_after", 64'(SD_REQ), 64'd0);
        SD_OK   = 1'b1;
        SD_DATA = 32'h44444444;
        cyc();
        SD_OK   = 1'b0;
        SD_DATA = '0;
        chk("rb_late_no_req", 64'(SD_REQ), 64'd0);
        CH_CS = 8'hFF;
        #1;
        chk("rb_late_no_ok", 64'(CH_OK), 64'd0);
        chk("rb_dout4_zero", 64'(dout(4)), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
